// File: rtl/adc_pkg.sv
// ============================================================================
// adc_pkg : shared constants and types for the ADC data path
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package adc_pkg;

   localparam int ADC_DW           = 16;
   localparam int ADC_AVG_LOG2_MAX = 8;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } adc_avg_st_t;

   // Sample counter width; a single-sample window still needs one bit.
   function automatic int avg_cnt_w(input int log2);
      return (log2 < 1) ? 1 : log2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adc_avg_minmax.sv
// ============================================================================
// adc_avg_minmax : running per-window minimum / maximum tracker
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module adc_avg_minmax
   import adc_pkg::*;
#(
   parameter int DW = ADC_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          sample_i,
   input  logic [DW-1:0] din_i,
   output logic [DW-1:0] min_o,
   output logic [DW-1:0] max_o
);

   logic [DW-1:0] run_min_q;
   logic [DW-1:0] run_max_q;

   // Outputs include the sample being presented, so the window's last sample counts.
   always_comb begin
      min_o = run_min_q;
      max_o = run_max_q;
      if (sample_i) begin
         if (din_i < run_min_q) min_o = din_i;
         if (din_i > run_max_q) max_o = din_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_min_q <= {DW{1'b1}};
         run_max_q <= '0;
      end else if (start_i) begin
         run_min_q <= {DW{1'b1}};
         run_max_q <= '0;
      end else if (sample_i) begin
         run_min_q <= min_o;
         run_max_q <= max_o;
      end
   end

endmodule

`default_nettype wire

// File: rtl/adc_avg.sv
// ============================================================================
// adc_avg : boxcar average over 2^AVG_LOG2 samples with valid/ready output
//           and sticky overrun; optional window min/max via ADC_AVG_MINMAX_EN
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module adc_avg
   import adc_pkg::*;
#(
   parameter int DW       = ADC_DW,
   parameter int AVG_LOG2 = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] din,
   input  logic          din_vld,
   input  logic          clr,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic          dout_rdy,
   output logic          ovr
`ifdef ADC_AVG_MINMAX_EN
   ,
   output logic [DW-1:0] dmin,
   output logic [DW-1:0] dmax
`endif
);

   localparam int AW   = DW + AVG_LOG2;
   localparam int CW   = avg_cnt_w(AVG_LOG2);
   localparam int HALF = (1 << AVG_LOG2) >> 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

   if (AVG_LOG2 < 0 || AVG_LOG2 > ADC_AVG_LOG2_MAX) begin : g_bad_log2
      $error("adc_avg: AVG_LOG2 out of range");
   end

   adc_avg_st_t   st_q, st_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          ovr_q, ovr_d;

   logic [AW-1:0] acc_sum;
   logic [AW-1:0] acc_rnd;
   logic [DW-1:0] res;
   logic          win_done;
   logic          xfer;
   logic          load;

   // The window sum can never exceed N*(2^DW-1), so rounding fits in AW bits.
   assign acc_sum  = acc_q + AW'(din);
   assign acc_rnd  = acc_sum + AW'(HALF);
   assign res      = DW'(acc_rnd >> AVG_LOG2);
   assign win_done = din_vld && (cnt_q == CNT_LAST);
   assign xfer     = (st_q == ST_FULL) && dout_rdy;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (din_vld) begin
         if (win_done) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_comb begin
      st_d   = st_q;
      ovr_d  = ovr_q;
      load   = 1'b0;
      if (clr) begin
         st_d  = ST_EMPTY;
         ovr_d = 1'b0;
      end else begin
         case (st_q)
            ST_EMPTY: begin
               if (win_done) begin
                  st_d = ST_FULL;
                  load = 1'b1;
               end
            end
            ST_FULL: begin
               if (win_done && xfer) begin
                  load = 1'b1;
               end else if (win_done) begin
                  ovr_d = 1'b1;
               end else if (xfer) begin
                  st_d = ST_EMPTY;
               end
            end
            default: st_d = ST_EMPTY;
         endcase
      end
      dout_d = load ? res : dout_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= ST_EMPTY;
         acc_q  <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         ovr_q  <= ovr_d;
      end
   end

   assign dout     = dout_q;
   assign dout_vld = (st_q == ST_FULL);
   assign ovr      = ovr_q;

`ifdef ADC_AVG_MINMAX_EN
   logic [DW-1:0] win_min;
   logic [DW-1:0] win_max;
   logic [DW-1:0] dmin_q;
   logic [DW-1:0] dmax_q;

   adc_avg_minmax #(
      .DW (DW)
   ) u_minmax (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (clr || win_done),
      .sample_i (din_vld && !clr),
      .din_i    (din),
      .min_o    (win_min),
      .max_o    (win_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmin_q <= {DW{1'b1}};
         dmax_q <= '0;
      end else if (load) begin
         dmin_q <= win_min;
         dmax_q <= win_max;
      end
   end

   assign dmin = dmin_q;
   assign dmax = dmax_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_avg.sv
// Bench for adc_avg: three instances (AVG_LOG2 = 3, 0, 8) share one stimulus
// stream; a window-level reference model feeds per-instance expected queues.
`default_nettype none

module tb_adc_avg;

   localparam int NI = 3;

   function automatic int lg(input int k);
      case (k)
         0:       return 3;
         1:       return 0;
         default: return 8;
      endcase
   endfunction

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        clr     = 1'b0;
   logic        din_vld = 1'b0;
   logic [15:0] din     = '0;
   logic        rdy  [NI];
   logic [15:0] dout [NI];
   logic        vld  [NI];
   logic        ovr  [NI];
`ifdef ADC_AVG_MINMAX_EN
   logic [15:0] dmn  [NI];
   logic [15:0] dmx  [NI];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      adc_avg #(
         .DW       (16),
         .AVG_LOG2 (lg(g))
      ) u_dut (
         .clk      (clk),
         .rst_n    (rst_n),
         .din      (din),
         .din_vld  (din_vld),
         .clr      (clr),
         .dout     (dout[g]),
         .dout_vld (vld[g]),
         .dout_rdy (rdy[g]),
         .ovr      (ovr[g])
`ifdef ADC_AVG_MINMAX_EN
         ,
         .dmin     (dmn[g]),
         .dmax     (dmx[g])
`endif
      );
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      logic [15:0] d;
      logic [15:0] lo;
      logic [15:0] hi;
   } exp_t;

   exp_t        expq [NI][$];
   longint      wsum [NI];
   int          wcnt [NI];
   bit          movr [NI];
   logic [15:0] wmin [NI];
   logic [15:0] wmax [NI];
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[L=%0d] got=%0h expected=%0h t=%0t", nm, lg(k), act, exp, $time);
      end
   endtask

   task automatic win_reset(input int k);
      wsum[k] = 0;
      wcnt[k] = 0;
      wmin[k] = 16'hFFFF;
      wmax[k] = 16'h0000;
   endtask

   // Advance instance k's model across the coming rising edge.
   task automatic model_step(input int k, input bit held, input bit xfer);
      longint n;
      exp_t   e;
      n = longint'(1) << lg(k);
      if (clr) begin
         win_reset(k);
         movr[k] = 1'b0;
         expq[k].delete();
      end else if (din_vld) begin
         wsum[k] += longint'(din);
         wcnt[k]++;
         if (din < wmin[k]) wmin[k] = din;
         if (din > wmax[k]) wmax[k] = din;
         if (longint'(wcnt[k]) == n) begin
            e.d  = 16'((wsum[k] + n / 2) / n);
            e.lo = wmin[k];
            e.hi = wmax[k];
            win_reset(k);
            if (!held || xfer) expq[k].push_back(e);
            else               movr[k] = 1'b1;
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (!rst_n) begin
            win_reset(k);
            movr[k] = 1'b0;
            expq[k].delete();
            chk("rst_vld",  k, 32'(vld[k]),  32'd0);
            chk("rst_ovr",  k, 32'(ovr[k]),  32'd0);
            chk("rst_dout", k, 32'(dout[k]), 32'd0);
`ifdef ADC_AVG_MINMAX_EN
            chk("rst_dmin", k, 32'(dmn[k]), 32'hFFFF);
            chk("rst_dmax", k, 32'(dmx[k]), 32'h0000);
`endif
         end else begin
            bit held;
            bit xfer;
            held = (expq[k].size() > 0);
            chk("dout_vld", k, 32'(vld[k]), 32'(held));
            chk("ovr",      k, 32'(ovr[k]), 32'(movr[k]));
            if (held && vld[k]) begin
               chk("dout", k, 32'(dout[k]), 32'(expq[k][0].d));
`ifdef ADC_AVG_MINMAX_EN
               chk("dmin", k, 32'(dmn[k]), 32'(expq[k][0].lo));
               chk("dmax", k, 32'(dmx[k]), 32'(expq[k][0].hi));
`endif
            end
            xfer = held && rdy[k];
            if (xfer) expq[k].delete(0);
            model_step(k, held, xfer);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input logic [15:0] d, input bit c);
      din_vld = v;
      din     = d;
      clr     = c;
      @(posedge clk);
      #2;
   endtask

   task automatic strobes(input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, d, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0);
   endtask

   task automatic do_clr();
      cyc(1'b0, 16'h0, 1'b1);
   endtask

   task automatic all_rdy(input bit r);
      for (int k = 0; k < NI; k++) rdy[k] = r;
   endtask

   initial begin
      logic [15:0] mm [8];
      mm = '{16'd5, 16'd9, 16'd1, 16'd7, 16'd3, 16'd3, 16'd3, 16'd3};
      all_rdy(1'b1);
      din_vld = 1'b1;
      din     = 16'hDEAD;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      idle(2);

      // Plain average and rounding.
      do_clr();
      strobes(16'hBFFF, 8);
      idle(3);
      strobes(16'h0000, 4);
      strobes(16'h0001, 4);
      idle(2);
      strobes(16'h0000, 5);
      strobes(16'h0001, 3);
      idle(2);

      // Overrun under back-pressure, then release.
      do_clr();
      rdy[0] = 1'b0;
      strobes(16'h1000, 16);
      strobes(16'h2000, 8);
      idle(2);
      rdy[0] = 1'b1;
      idle(2);

      // Ready on the exact completion cycle: reload, no overrun.
      do_clr();
      rdy[0] = 1'b0;
      strobes(16'h1000, 8);
      idle(2);
      strobes(16'h2000, 7);
      rdy[0] = 1'b1;
      cyc(1'b1, 16'h2000, 1'b0);
      rdy[0] = 1'b0;
      idle(2);
      rdy[0] = 1'b1;
      idle(2);

      // Reset mid-window (strobe held high through reset).
      do_clr();
      strobes(16'h0007, 4);
      rst_n   = 1'b0;
      din_vld = 1'b1;
      din     = 16'h0055;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      strobes(16'h0008, 8);
      idle(2);

      // Overrun set, then clr with a coincident strobe mid-window.
      rdy[0] = 1'b0;
      strobes(16'h1000, 16);
      strobes(16'h0007, 4);
      cyc(1'b1, 16'h00FF, 1'b1);
      rdy[0] = 1'b1;
      strobes(16'h0008, 8);
      idle(2);

      // Full-scale long window and per-sample echo.
      do_clr();
      strobes(16'hFFFF, 256);
      idle(3);

      // Window extremes.
      do_clr();
      for (int i = 0; i < 8; i++) cyc(1'b1, mm[i], 1'b0);
      idle(2);

      // Randomized traffic.
      for (int i = 0; i < 2500; i++) begin
         logic [15:0] d;
         case ($urandom_range(0, 3))
            0:       d = 16'h0000;
            1:       d = 16'hFFFF;
            default: d = 16'($urandom);
         endcase
         for (int k = 0; k < NI; k++) rdy[k] = ($urandom_range(0, 3) != 0);
         cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 79) == 0));
      end

      all_rdy(1'b1);
      idle(4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

`default_nettype wire
